// File: rtl/memshare_rqst_sched_if.sv
// Request/grant handshake bundle between the share skid buffer, the scheduler
// and the shared memory port. The slave modport is the scheduler's view.
interface memshare_rqst_sched_if #(
    parameter int SHARE_GROUP_SIZE = 5,
    parameter int IDX_W            = $clog2(SHARE_GROUP_SIZE)
);
    logic [SHARE_GROUP_SIZE-1:0] rqst_flag_i;
    logic                        rqst_valid_i;
    logic                        rqst_ready_o;
    logic [SHARE_GROUP_SIZE-1:0] gnt_onehot_o;
    logic [IDX_W-1:0]            gnt_idx_o;
    logic                        gnt_valid_o;
    logic                        gnt_ready_i;

    modport master (
        output rqst_flag_i, rqst_valid_i, gnt_ready_i,
        input  rqst_ready_o, gnt_onehot_o, gnt_idx_o, gnt_valid_o
    );

    modport slave (
        input  rqst_flag_i, rqst_valid_i, gnt_ready_i,
        output rqst_ready_o, gnt_onehot_o, gnt_idx_o, gnt_valid_o
    );
endinterface

// File: rtl/memshare_rqst_sched.sv
// Round-robin scheduler serialising one share group's requests onto a single memory port.
// Optional perf counters (conflict_cnt_o, stall_cnt_o) enabled by MEMSHARE_SCHED_PERF_EN.
module memshare_rqst_sched #(
    parameter int SHARE_GROUP_SIZE = 5,
    parameter int IDX_W            = $clog2(SHARE_GROUP_SIZE)
) (
    input  logic        sys_clk,
    input  logic        rstn,
    memshare_rqst_sched_if.slave bus,
    output logic        skid_sel_o,
    output logic        update_mask_o,
`ifdef MEMSHARE_SCHED_PERF_EN
    output logic        busy_o,
    output logic [15:0] conflict_cnt_o,
    output logic [15:0] stall_cnt_o
`else
    output logic        busy_o
`endif
);
    localparam int N = SHARE_GROUP_SIZE;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [IDX_W:0]   NUM_REQ  = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [0:0]       state_q, state_d;
    logic [N-1:0]     pend_q, pend_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             served_q, served_d;

    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    logic [N-1:0]     gnt_onehot;
    logic [IDX_W:0]   scan;
    logic             last_bit;
    logic             rqst_ready;
    logic             vec_load;
    logic             in_grant;

    // Rotating priority scan starting at ptr; depends on registers only.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            if (!gnt_found && pend_q[scan[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[IDX_W-1:0];
            end
        end
        gnt_onehot = gnt_found ? (N'(1) << gnt_idx) : '0;
    end

    assign in_grant   = (state_q == ST_GRANT);
    assign last_bit   = ((pend_q & ~gnt_onehot) == '0);
    assign rqst_ready = !in_grant || (bus.gnt_ready_i && last_bit);
    assign vec_load   = rqst_ready && bus.rqst_valid_i && (bus.rqst_flag_i != '0);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ptr_d    = ptr_q;
        served_d = served_q;
        if (in_grant && bus.gnt_ready_i) begin
            pend_d   = pend_q & ~gnt_onehot;
            ptr_d    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
            served_d = 1'b1;
            if (last_bit && !vec_load) begin
                state_d = ST_IDLE;
            end
        end
        // A new vector either leaves IDLE or chains directly behind the last grant.
        if (vec_load) begin
            pend_d   = bus.rqst_flag_i;
            served_d = 1'b0;
            state_d  = ST_GRANT;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            ptr_q    <= '0;
            served_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            served_q <= served_d;
        end
    end

    assign bus.rqst_ready_o = rqst_ready;
    assign bus.gnt_onehot_o = gnt_onehot;
    assign bus.gnt_idx_o    = gnt_idx;
    assign bus.gnt_valid_o  = in_grant;
    assign skid_sel_o       = in_grant && served_q;
    assign update_mask_o    = in_grant && !rqst_ready;
    assign busy_o           = (pend_q != '0);

`ifdef MEMSHARE_SCHED_PERF_EN
    logic [15:0] conflict_cnt_q, stall_cnt_q;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            conflict_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (vec_load && ($countones(bus.rqst_flag_i) > 1) && (conflict_cnt_q != 16'hFFFF)) begin
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
            end
            if (update_mask_o && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign stall_cnt_o    = stall_cnt_q;
`endif
endmodule

// File: tb/tb_memshare_rqst_sched.sv
// Directed-vector bench for memshare_rqst_sched with hand-computed grant sequences.
module tb_memshare_rqst_sched;
    logic sys_clk;
    logic rstn;
    logic skid_sel;
    logic update_mask;
    logic busy;
    int   vecCount;
    int   missCount;
`ifdef MEMSHARE_SCHED_PERF_EN
    logic [15:0] conflictCnt;
    logic [15:0] stallCnt;
`endif

    memshare_rqst_sched_if #(.SHARE_GROUP_SIZE(5)) bus ();

    memshare_rqst_sched #(.SHARE_GROUP_SIZE(5)) dut (
        .sys_clk        (sys_clk),
        .rstn           (rstn),
        .bus            (bus),
        .skid_sel_o     (skid_sel),
        .update_mask_o  (update_mask),
`ifdef MEMSHARE_SCHED_PERF_EN
        .busy_o         (busy),
        .conflict_cnt_o (conflictCnt),
        .stall_cnt_o    (stallCnt)
`else
        .busy_o         (busy)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and let combinational outputs settle.
    task automatic applyStimulus(input logic valid, input logic [4:0] flags, input logic gntReady);
        @(negedge sys_clk);
        bus.rqst_valid_i = valid;
        bus.rqst_flag_i  = flags;
        bus.gnt_ready_i  = gntReady;
        #1;
    endtask

    task automatic checkGrant(input string tag, input logic [2:0] idx, input logic skid,
                              input logic umask, input logic ready);
        checkOutput({tag, " valid"}, 32'(bus.gnt_valid_o), 32'd1);
        checkOutput({tag, " idx"}, 32'(bus.gnt_idx_o), 32'(idx));
        checkOutput({tag, " onehot"}, 32'(bus.gnt_onehot_o), 32'(5'b00001 << idx));
        checkOutput({tag, " skid"}, 32'(skid_sel), 32'(skid));
        checkOutput({tag, " umask"}, 32'(update_mask), 32'(umask));
        checkOutput({tag, " ready"}, 32'(bus.rqst_ready_o), 32'(ready));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " valid"}, 32'(bus.gnt_valid_o), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " ready"}, 32'(bus.rqst_ready_o), 32'd1);
        checkOutput({tag, " umask"}, 32'(update_mask), 32'd0);
    endtask

    initial begin
        vecCount         = 0;
        missCount        = 0;
        rstn             = 1'b0;
        bus.rqst_valid_i = 1'b0;
        bus.rqst_flag_i  = '0;
        bus.gnt_ready_i  = 1'b0;

        applyStimulus(1'b0, 5'b00000, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b0);
        checkIdle("reset");
        checkOutput("reset onehot", 32'(bus.gnt_onehot_o), 32'd0);
        checkOutput("reset idx", 32'(bus.gnt_idx_o), 32'd0);
        checkOutput("reset skid", 32'(skid_sel), 32'd0);
`ifdef MEMSHARE_SCHED_PERF_EN
        checkOutput("reset conflict", 32'(conflictCnt), 32'd0);
`endif
        rstn = 1'b1;

        // 10011 from ptr 0: grants 0,1,4, ptr wraps back to 0
        applyStimulus(1'b1, 5'b10011, 1'b1);
        checkOutput("v10011 accept", 32'(bus.rqst_ready_o), 32'd1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("v10011 g0", 3'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("v10011 busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("v10011 g1", 3'd1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("v10011 g4", 3'd4, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkIdle("v10011 done");

        // Single request 00100 from ptr 0; leaves ptr at 3
        applyStimulus(1'b1, 5'b00100, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("v00100 g2", 3'd2, 1'b0, 1'b0, 1'b1);
        checkOutput("v00100 busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkIdle("v00100 done");

        // All requestors from ptr 3: order 3,4,0,1,2
        applyStimulus(1'b1, 5'b11111, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("wrap g3", 3'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("wrap g4", 3'd4, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("wrap g0", 3'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("wrap g1", 3'd1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("wrap g2", 3'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkIdle("wrap done");

        // 00110 from ptr 3 with the port stalled three cycles
        applyStimulus(1'b1, 5'b00110, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'b00000, 1'b0);
            checkGrant($sformatf("stall%0d", i), 3'd1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("stall%0d busy", i), 32'(busy), 32'd1);
        end
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("stall g1", 3'd1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("stall g2", 3'd2, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkIdle("stall done");

        // Back-to-back 00001 then 00010, no idle bubble between them
        applyStimulus(1'b1, 5'b00001, 1'b1);
        applyStimulus(1'b1, 5'b00010, 1'b1);
        checkGrant("b2b g0", 3'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("b2b g1", 3'd1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkIdle("b2b done");

        // Zero vector in IDLE is consumed without a grant
        applyStimulus(1'b1, 5'b00000, 1'b1);
        checkOutput("zero accept", 32'(bus.rqst_ready_o), 32'd1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkIdle("zero after");

        // 11100 from ptr 2, reset after the first grant
        applyStimulus(1'b1, 5'b11100, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("rst g2", 3'd2, 1'b0, 1'b1, 1'b0);
        @(negedge sys_clk);
        rstn = 1'b0;
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkIdle("rst mid");
`ifdef MEMSHARE_SCHED_PERF_EN
        checkOutput("rst conflict", 32'(conflictCnt), 32'd0);
`endif
        rstn = 1'b1;
        applyStimulus(1'b1, 5'b11111, 1'b1);
        applyStimulus(1'b0, 5'b00000, 1'b1);
        checkGrant("rst ptr0", 3'd0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule

// File: doc/memshare_rqst_sched.md
Name: memshare_rqst_sched

Overview:
- Round-robin scheduler for one memory-share group.
- Accepts a vector of per-requestor access flags, from the request flag generator via the share skid buffer.
- Serialises conflicting requests onto the single shared memory port, one grant per cycle.
- Drives the skid-buffer select and update-mask controls so upstream flags stay frozen while deferred requestors are served.

Parameters:
- SHARE_GROUP_SIZE, 5, number of requestors in the share group (N, 2..16).
- IDX_W, $clog2(SHARE_GROUP_SIZE), width of the grant index.

Ports:
- sys_clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- rqst_flag_i  in  N  request flags, bit i = requestor i.
- rqst_valid_i  in  1  rqst_flag_i valid.
- rqst_ready_o  out  1  scheduler accepts a vector this cycle.
- gnt_onehot_o  out  N  one-hot grant to the shared port.
- gnt_idx_o  out  IDX_W  binary index of the granted requestor.
- gnt_valid_o  out  1  grant valid.
- gnt_ready_i  in  1  shared port consumes the grant.
- skid_sel_o  out  1  1 = skid buffer outputs stored flags (deferred service).
- update_mask_o  out  1  1 = skid buffer holds its contents.
- busy_o  out  1  pending vector non-empty.

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE, pend=0, ptr=0, served_f=0.
  - All outputs 0 except rqst_ready_o=1.
  - Reset mid-service discards pending requests; no grant is issued in the cycle after reset.
- Registers:
  - pend[N]: requests not yet granted.
  - ptr[IDX_W]: highest-priority index.
  - served_f: at least one bit of the current vector has been granted.
  - state: IDLE or GRANT.
- Grant selection (combinational from registers only):
  - First set bit of pend scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - gnt_idx_o = its index; gnt_onehot_o = 1<<gnt_idx_o; gnt_valid_o = (state==GRANT).
- IDLE:
  - rqst_ready_o=1.
  - rqst_valid_i=1 and rqst_flag_i!=0: pend<=rqst_flag_i, served_f<=0, state<=GRANT.
  - rqst_valid_i=1 and rqst_flag_i==0: vector consumed, no state change.
- GRANT, gnt_ready_i=0:
  - All registers and grant outputs held stable.
  - rqst_ready_o=0.
- GRANT, gnt_ready_i=1:
  - pend<=pend & ~gnt_onehot_o.
  - ptr<=(gnt_idx_o==N-1) ? 0 : gnt_idx_o+1.
  - served_f<=1.
  - If the granted bit was the last pending bit: rqst_ready_o=1 (combinational).
    - rqst_valid_i=1 with non-zero flags: load the new vector with served_f<=0, stay GRANT (back-to-back, no bubble).
    - Otherwise: state<=IDLE.
  - Else: stay GRANT, rqst_ready_o=0.
- Derived outputs:
  - skid_sel_o = (state==GRANT) & served_f.
  - update_mask_o = (state==GRANT) & ~rqst_ready_o.
  - busy_o = (pend!=0).
- Timing:
  - Latency: vector accepted at edge t, first grant visible at cycle t+1.
  - A vector with k set bits needs exactly k gnt_ready_i handshakes.
- Fairness: ptr advances past the granted requestor only on a handshake, so every pending bit is granted within N handshakes.

Optional Feature:
- Macro: MEMSHARE_SCHED_PERF_EN.
- Defined:
  - Adds output conflict_cnt_o (16 bits): saturating count of accepted vectors with popcount>1, held at 16'hFFFF on saturation, reset to 0.
  - Adds output stall_cnt_o (16 bits): saturating count of cycles with update_mask_o=1.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset, then one vector 5'b00100 with gnt_ready_i=1 → cycle+1: gnt_idx_o=2, skid_sel_o=0; next cycle IDLE, ptr=3.
- From ptr=0, vector 5'b10011 with gnt_ready_i=1 → grants idx 0,1,4 on consecutive cycles; skid_sel_o=0,1,1; update_mask_o=1,1,0; rqst_ready_o=1 only on the third cycle.
- With ptr=3, vector 5'b11111 → grant order 3,4,0,1,2, verifying wrap-around.
- Vector 5'b00110 with gnt_ready_i low for 3 cycles → gnt_idx_o=1 held stable and pend unchanged; then grants 1,2.
- Back-to-back vectors 5'b00001 then 5'b00010 with rqst_valid_i held → grants 0 then 1 with no idle cycle; zero vector accepted in IDLE → no grant.
- rstn low while serving 5'b11100 after the first grant → next cycle gnt_valid_o=0, busy_o=0, ptr=0; with PERF_EN, conflict_cnt_o=0.
